// File: rtl/oric_mem_pkg.sv
// rtl/oric_mem_pkg.sv - shared types and constants for the Oric RAM to SDRAM bridge
//
// Provides the bridge FSM state enum, the latched request record (req_t),
// the byte-lane encodings and the ROM window tag, plus a lane-select helper.
package oric_mem_pkg;

    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        IDLE  = 2'd1,
        WAIT  = 2'd2,
        ISSUE = 2'd3
    } state_t;

    typedef struct packed {
        logic [15:0] a;
        logic        we;
        logic [1:0]  ds;
        logic [7:0]  d;
    } req_t;

    localparam logic [1:0] DS_LO   = 2'b01;
    localparam logic [1:0] DS_HI   = 2'b10;
    localparam logic [1:0] DS_RD   = 2'b11;
    localparam logic [1:0] ROM_WIN = 2'b11;

    // A write touches only the lane that holds the addressed byte; reads fetch the whole word.
    function automatic logic [1:0] lane_ds(input logic we, input logic a0);
        if (!we) begin
            return DS_RD;
        end
        return a0 ? DS_HI : DS_LO;
    endfunction

endpackage

// File: rtl/oric_strobe_sync.sv
// rtl/oric_strobe_sync.sv - strobe synchroniser and access trigger detector
//
// Ports:
//   clk, res_n          clock, asynchronous active-low reset
//   cpu_ad/cpu_d        core address and write data (synchronised alongside the strobes)
//   cpu_cs/oe/we        core strobes
//   trig                one-cycle pulse: a new access must be forwarded
//   trig_req            request record captured from the synchronised inputs
//   excl_rd             a read of the excluded ROM window is in progress
module oric_strobe_sync
    import oric_mem_pkg::*;
#(
    parameter int ROM_EXCLUDE = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        res_n,
    input  logic [15:0] cpu_ad,
    input  logic [7:0]  cpu_d,
    input  logic        cpu_cs,
    input  logic        cpu_oe,
    input  logic        cpu_we,
    output logic        trig,
    output req_t        trig_req,
    output logic        excl_rd
);

    logic [SYNC_STAGES-1:0] cs_q, cs_d;
    logic [SYNC_STAGES-1:0] oe_q, oe_d;
    logic [SYNC_STAGES-1:0] we_q, we_d;
    logic [15:0]            ad_q [SYNC_STAGES];
    logic [15:0]            ad_d [SYNC_STAGES];
    logic [7:0]             dd_q [SYNC_STAGES];
    logic [7:0]             dd_d [SYNC_STAGES];

    logic        o_rd_q, o_rd_d;
    logic        o_wr_q, o_wr_d;
    logic [15:0] o_ad_q, o_ad_d;

    logic        s_cs, s_oe, s_we;
    logic [15:0] s_ad;
    logic [7:0]  s_d;
    logic        rom, sel, rd, wr;

    always_comb begin
        cs_d[0] = cpu_cs;
        oe_d[0] = cpu_oe;
        we_d[0] = cpu_we;
        ad_d[0] = cpu_ad;
        dd_d[0] = cpu_d;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            cs_d[i] = cs_q[i-1];
            oe_d[i] = oe_q[i-1];
            we_d[i] = we_q[i-1];
            ad_d[i] = ad_q[i-1];
            dd_d[i] = dd_q[i-1];
        end

        s_cs = cs_q[SYNC_STAGES-1];
        s_oe = oe_q[SYNC_STAGES-1];
        s_we = we_q[SYNC_STAGES-1];
        s_ad = ad_q[SYNC_STAGES-1];
        s_d  = dd_q[SYNC_STAGES-1];

        rom = (ROM_EXCLUDE != 0) && (s_ad[15:14] == ROM_WIN);
        sel = s_cs & ~rom;
        rd  = sel & s_oe;
        wr  = sel & s_we;

        o_rd_d = rd;
        o_wr_d = wr;
        o_ad_d = s_ad;

        // A held read strobe re-triggers whenever the core moves the address under it.
        trig = (rd & ~o_rd_q) | (wr & ~o_wr_q) | (rd & (s_ad != o_ad_q));

        trig_req.a  = s_ad;
        trig_req.we = wr;
        trig_req.ds = lane_ds(wr, s_ad[0]);
        trig_req.d  = s_d;

        excl_rd = s_cs & s_oe & rom;
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            cs_q   <= '0;
            oe_q   <= '0;
            we_q   <= '0;
            ad_q   <= '{default: '0};
            dd_q   <= '{default: '0};
            o_rd_q <= 1'b0;
            o_wr_q <= 1'b0;
            o_ad_q <= '0;
        end else begin
            cs_q   <= cs_d;
            oe_q   <= oe_d;
            we_q   <= we_d;
            ad_q   <= ad_d;
            dd_q   <= dd_d;
            o_rd_q <= o_rd_d;
            o_wr_q <= o_wr_d;
            o_ad_q <= o_ad_d;
        end
    end

endmodule

// File: rtl/oric_sdram_bridge.sv
// rtl/oric_sdram_bridge.sv - Oric core RAM strobes to SDRAM toggle-handshake port
//
// Ports:
//   clk, res_n                 SDRAM-domain clock, asynchronous active-low reset
//   cpu_ad/cpu_d/cpu_cs/oe/we  core RAM interface; cpu_q returns the read byte
//   port_req/port_ack          toggle handshake with the SDRAM controller port
//   port_a/ds/we/d             latched request; port_q is the returned read word
//   busy                       request outstanding or pending
//   overrun                    sticky: an access was dropped
module oric_sdram_bridge
    import oric_mem_pkg::*;
#(
    parameter int ROM_EXCLUDE = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        res_n,
    input  logic [15:0] cpu_ad,
    input  logic [7:0]  cpu_d,
    input  logic        cpu_cs,
    input  logic        cpu_oe,
    input  logic        cpu_we,
    output logic [7:0]  cpu_q,
    output logic        port_req,
    input  logic        port_ack,
    output logic [15:0] port_a,
    output logic [1:0]  port_ds,
    output logic        port_we,
    output logic [15:0] port_d,
    input  logic [15:0] port_q,
    output logic        busy,
    output logic        overrun
);

    localparam req_t REQ_RESET = '{a: 16'h0000, we: 1'b0, ds: DS_RD, d: 8'h00};

    logic   trig;
    req_t   trig_req;
    logic   excl_rd;

    state_t     state_q, state_d;
    logic       port_req_q, port_req_d;
    req_t       req_q, req_d;
    req_t       pend_q, pend_d;
    logic       pend_v_q, pend_v_d;
    logic       overrun_q, overrun_d;
    logic [7:0] cpu_q_q, cpu_q_d;
    logic       pend_v_eff;
    logic       acked;

    oric_strobe_sync #(
        .ROM_EXCLUDE (ROM_EXCLUDE),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .res_n    (res_n),
        .cpu_ad   (cpu_ad),
        .cpu_d    (cpu_d),
        .cpu_cs   (cpu_cs),
        .cpu_oe   (cpu_oe),
        .cpu_we   (cpu_we),
        .trig     (trig),
        .trig_req (trig_req),
        .excl_rd  (excl_rd)
    );

    always_comb begin
        state_d    = state_q;
        port_req_d = port_req_q;
        req_d      = req_q;
        pend_d     = pend_q;
        pend_v_d   = pend_v_q;
        overrun_d  = overrun_q;
        cpu_q_d    = cpu_q_q;
        pend_v_eff = pend_v_q;
        acked      = (port_ack == port_req_q);

        if (excl_rd) begin
            cpu_q_d = 8'h00;
        end

        case (state_q)
            SYNC: begin
                // Adopt the controller's ack phase so the first real toggle is the first request.
                if (port_ack != port_req_q) begin
                    port_req_d = port_ack;
                end
                state_d = IDLE;
            end
            IDLE: begin
                if (trig) begin
                    req_d      = trig_req;
                    port_req_d = ~port_req_q;
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                if (acked && !req_q.we) begin
                    cpu_q_d = req_q.a[0] ? port_q[15:8] : port_q[7:0];
                end
            end
            ISSUE: begin
                req_d      = pend_q;
                port_req_d = ~port_req_q;
                pend_v_d   = 1'b0;
                pend_v_eff = 1'b0;
                state_d    = WAIT;
            end
            default: begin
                state_d = SYNC;
            end
        endcase

        // While a request is in flight new accesses go to the single pending slot.
        // A queued write must never be lost, so it blocks; a queued read is superseded.
        if (trig && (state_q == WAIT || state_q == ISSUE)) begin
            if (!pend_v_eff || !pend_q.we) begin
                pend_d   = trig_req;
                pend_v_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end

        // Decided after the slot update so a trigger landing on the ack cycle is issued next.
        if (state_q == WAIT && acked) begin
            state_d = pend_v_d ? ISSUE : IDLE;
        end
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state_q    <= SYNC;
            port_req_q <= 1'b0;
            req_q      <= REQ_RESET;
            pend_q     <= REQ_RESET;
            pend_v_q   <= 1'b0;
            overrun_q  <= 1'b0;
            cpu_q_q    <= 8'h00;
        end else begin
            state_q    <= state_d;
            port_req_q <= port_req_d;
            req_q      <= req_d;
            pend_q     <= pend_d;
            pend_v_q   <= pend_v_d;
            overrun_q  <= overrun_d;
            cpu_q_q    <= cpu_q_d;
        end
    end

    assign port_req = port_req_q;
    assign port_a   = req_q.a;
    assign port_ds  = req_q.ds;
    assign port_we  = req_q.we;
    assign port_d   = {req_q.d, req_q.d};
    assign cpu_q    = cpu_q_q;
    assign overrun  = overrun_q;
    assign busy     = (state_q != IDLE && state_q != SYNC) | pend_v_q;

endmodule

// File: tb/tb_oric_sdram_bridge.sv
// tb/tb_oric_sdram_bridge.sv - self-checking bench for oric_sdram_bridge
module tb_oric_sdram_bridge;

    typedef struct packed {
        logic [15:0] a;
        logic        we;
        logic [1:0]  ds;
        logic [7:0]  d;
    } exp_t;

    logic        clk = 1'b0;
    logic        res_n = 1'b0;
    logic [15:0] cpu_ad = '0;
    logic [7:0]  cpu_d = '0;
    logic        cpu_cs = 1'b0;
    logic        cpu_oe = 1'b0;
    logic        cpu_we = 1'b0;
    logic [7:0]  cpu_q;
    logic        port_req;
    logic        port_ack = 1'b0;
    logic [15:0] port_a;
    logic [1:0]  port_ds;
    logic        port_we;
    logic [15:0] port_d;
    logic [15:0] port_q = '0;
    logic        busy;
    logic        overrun;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t exp_q[$];

    int          cyc = 0;
    bit          model_en = 1'b0;
    bit          in_flight = 1'b0;
    int          ack_dly = 6;
    int          ack_cnt = 0;
    int          ack_cyc = 0;
    int          last_gap = 0;
    int          n_tog = 0;
    logic [15:0] rdata = '0;

    oric_sdram_bridge dut (
        .clk      (clk),
        .res_n    (res_n),
        .cpu_ad   (cpu_ad),
        .cpu_d    (cpu_d),
        .cpu_cs   (cpu_cs),
        .cpu_oe   (cpu_oe),
        .cpu_we   (cpu_we),
        .cpu_q    (cpu_q),
        .port_req (port_req),
        .port_ack (port_ack),
        .port_a   (port_a),
        .port_ds  (port_ds),
        .port_we  (port_we),
        .port_d   (port_d),
        .port_q   (port_q),
        .busy     (busy),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // SDRAM controller model: accepts each req toggle, scores it, acks after ack_dly clocks.
    always @(negedge clk) begin
        exp_t e;
        if (model_en) begin
            if (in_flight) begin
                if (ack_cnt <= 1) begin
                    port_ack  = port_req;
                    in_flight = 1'b0;
                    ack_cyc   = cyc;
                end else begin
                    ack_cnt--;
                end
            end else if (port_req != port_ack) begin
                in_flight = 1'b1;
                ack_cnt   = ack_dly;
                n_tog++;
                last_gap  = cyc - ack_cyc;
                port_q    = rdata;
                if (exp_q.size() == 0) begin
                    check("unexpected_req", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("req_a", port_a, e.a);
                    check("req_we", port_we, e.we);
                    check("req_ds", port_ds, e.ds);
                    if (e.we) check("req_d", port_d, {e.d, e.d});
                end
            end
        end
    end

    function automatic exp_t exp_rd(input logic [15:0] a);
        return '{a: a, we: 1'b0, ds: 2'b11, d: 8'h00};
    endfunction

    function automatic exp_t exp_wr(input logic [15:0] a, input logic [7:0] d);
        logic [1:0] ds;
        ds = a[0] ? 2'b10 : 2'b01;
        return '{a: a, we: 1'b1, ds: ds, d: d};
    endfunction

    // Called at a negedge; returns at a negedge with strobes released.
    task automatic cpu_read(input logic [15:0] a, input int hold);
        cpu_ad = a; cpu_d = 8'h00; cpu_cs = 1'b1; cpu_oe = 1'b1;
        repeat (hold) @(negedge clk);
        cpu_cs = 1'b0; cpu_oe = 1'b0;
    endtask

    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d, input int hold);
        cpu_ad = a; cpu_d = d; cpu_cs = 1'b1; cpu_we = 1'b1;
        repeat (hold) @(negedge clk);
        cpu_cs = 1'b0; cpu_we = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        repeat (4) @(negedge clk);
        while ((busy || in_flight || port_req !== port_ack) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", n >= 300, 0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int tog0;
        int n;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_port_req", port_req, 0);
        check("rst_port_a", port_a, 16'h0000);
        check("rst_port_ds", port_ds, 2'b11);
        check("rst_port_we", port_we, 0);
        check("rst_port_d", port_d, 16'h0000);
        check("rst_cpu_q", cpu_q, 8'h00);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);
        res_n = 1'b1;
        model_en = 1'b1;
        repeat (3) @(negedge clk);

        // Plain read, odd address selects high byte
        tog0 = n_tog;
        ack_dly = 6; rdata = 16'hAB12;
        exp_q.push_back(exp_rd(16'h1235));
        cpu_read(16'h1235, 4);
        wait_idle();
        check("rd_toggles", n_tog - tog0, 1);
        check("rd_cpu_q", cpu_q, 8'hAB);
        check("rd_busy", busy, 0);

        // Writes to even and odd bytes
        ack_dly = 3;
        exp_q.push_back(exp_wr(16'h0400, 8'h5A));
        cpu_write(16'h0400, 8'h5A, 3);
        wait_idle();
        check("wr_port_d", port_d, 16'h5A5A);
        exp_q.push_back(exp_wr(16'h0401, 8'hC3));
        cpu_write(16'h0401, 8'hC3, 3);
        wait_idle();
        check("wr_keeps_cpu_q", cpu_q, 8'hAB);

        // ROM window read: nothing forwarded, zero returned
        tog0 = n_tog;
        cpu_read(16'hC010, 4);
        wait_idle();
        check("rom_toggles", n_tog - tog0, 0);
        check("rom_cpu_q", cpu_q, 8'h00);

        // Read queued behind a slow write
        tog0 = n_tog;
        ack_dly = 10; rdata = 16'h3344;
        exp_q.push_back(exp_wr(16'h0100, 8'h11));
        exp_q.push_back(exp_rd(16'h0200));
        cpu_write(16'h0100, 8'h11, 2);
        cpu_read(16'h0200, 3);
        wait_idle();
        check("pend_toggles", n_tog - tog0, 2);
        // Ack driven at a negedge is sampled one posedge later; the follow-on toggle is one clock after that.
        check("pend_issue_gap", last_gap, 2);
        check("pend_cpu_q", cpu_q, 8'h44);
        check("pend_overrun", overrun, 0);

        // Third write while a write is already pending is dropped
        tog0 = n_tog;
        ack_dly = 12;
        exp_q.push_back(exp_wr(16'h0010, 8'hA0));
        exp_q.push_back(exp_wr(16'h0011, 8'hA1));
        cpu_write(16'h0010, 8'hA0, 2);
        @(negedge clk);
        cpu_write(16'h0011, 8'hA1, 2);
        @(negedge clk);
        cpu_write(16'h0012, 8'hA2, 2);
        wait_idle();
        check("ovr_toggles", n_tog - tog0, 2);
        check("ovr_flag", overrun, 1);

        // Address walking under a held read strobe
        tog0 = n_tog;
        ack_dly = 2; rdata = 16'h7788;
        exp_q.push_back(exp_rd(16'h0300));
        exp_q.push_back(exp_rd(16'h0301));
        exp_q.push_back(exp_rd(16'h0302));
        cpu_ad = 16'h0300; cpu_cs = 1'b1; cpu_oe = 1'b1;
        repeat (12) @(negedge clk);
        cpu_ad = 16'h0301;
        repeat (12) @(negedge clk);
        cpu_ad = 16'h0302;
        repeat (12) @(negedge clk);
        cpu_cs = 1'b0; cpu_oe = 1'b0;
        wait_idle();
        check("walk_toggles", n_tog - tog0, 3);
        check("walk_cpu_q", cpu_q, 8'h88);
        check("ovr_sticky", overrun, 1);

        // Reset in the middle of a request, controller ack left at 1
        ack_dly = 50; rdata = 16'h0000;
        exp_q.push_back(exp_rd(16'h0500));
        cpu_read(16'h0500, 4);
        n = 0;
        while (!in_flight && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("mid_wait_timeout", n >= 50, 0);
        check("mid_wait_busy", busy, 1);
        model_en = 1'b0;
        in_flight = 1'b0;
        port_ack = 1'b1;
        res_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst2_port_req", port_req, 0);
        check("rst2_busy", busy, 0);
        res_n = 1'b1;
        @(negedge clk);
        check("sync_port_req", port_req, 1);
        check("sync_busy", busy, 0);
        check("sync_overrun", overrun, 0);
        tog0 = n_tog;
        model_en = 1'b1;
        repeat (5) @(negedge clk);
        check("sync_no_toggle", n_tog - tog0, 0);

        // Bridge still usable after resync
        ack_dly = 3; rdata = 16'hCAFE;
        exp_q.push_back(exp_rd(16'h0501));
        cpu_read(16'h0501, 4);
        wait_idle();
        check("post_rst_cpu_q", cpu_q, 8'hCA);
        check("post_rst_toggles", n_tog - tog0, 1);
        check("exp_q_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog cycles=%0d", cyc);
        $fatal(1);
    end

endmodule
